// File: rtl/rnf_txreq_if.sv
// Request flit format plus the TXREQ handshake bundle between the RN-F request
// logic, the transmit stage and the HN-F receive stage.
// The master modport is the transmit stage's view; slave is the surrounding logic.
package rnf_txreq_pkg;
  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgt_id;
    logic [6:0]  src_id;
    logic [7:0]  txn_id;
    logic [5:0]  opcode;
    logic [31:0] addr;
  } reqflit_t;
endpackage

interface rnf_txreq_if;
  import rnf_txreq_pkg::*;

  reqflit_t req_in;
  logic     req_in_valid;
  logic     req_in_ready;
  reqflit_t TXREQFLIT;
  logic     TXREQFLITV;
  logic     TXREQFLITPEND;
  logic     TXREQLCRDV;

  modport master (
    input  req_in, req_in_valid, TXREQLCRDV,
    output req_in_ready, TXREQFLIT, TXREQFLITV, TXREQFLITPEND
  );

  modport slave (
    output req_in, req_in_valid, TXREQLCRDV,
    input  req_in_ready, TXREQFLIT, TXREQFLITV, TXREQFLITPEND
  );
endinterface

// File: rtl/rnf_txreq.sv
// RN-F TXREQ link stage: buffers request flits and launches them against L-credits.
// Latency: push to FLITV is two cycles (PEND the cycle after push, FLITV one later).
// Backpressure: req_in_ready drops when the buffer is full or in reset; no credit, no issue.
module rnf_txreq
  import rnf_txreq_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int MAX_CRD = 15,
  parameter int HN_ID   = 0
) (
  input  logic       clock,
  input  logic       reset,
  rnf_txreq_if.master tx,
  output logic [3:0] crd_count,
  output logic       crd_overflow
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  reqflit_t    mem [QDEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        issue;
  reqflit_t    head;
  reqflit_t    launch_dat;
  reqflit_t    out_q;
  logic        launch_q;
  logic [3:0]  crd_next;
  logic        ovf_set;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign tx.req_in_ready = !full && !reset;
  assign push            = tx.req_in_valid && tx.req_in_ready;

  // Issue looks only at registered state so PEND is a clean early warning.
  assign issue = !empty && (crd_count != 4'd0);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign tx.TXREQFLITPEND = issue;
  assign tx.TXREQFLITV    = launch_q;
  assign tx.TXREQFLIT     = out_q;

  // Flit storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx.req_in;
  end

  // Buffer pointers; reset discards anything queued.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Retarget the head flit at the home node; every other field passes through.
  always_comb begin
    launch_dat        = head;
    launch_dat.tgt_id = 7'(HN_ID);
  end

  // Launch register: holds the flit only in the cycle it is valid, zero otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q    <= '0;
      launch_q <= 1'b0;
    end else if (issue) begin
      out_q    <= launch_dat;
      launch_q <= 1'b1;
    end else begin
      out_q    <= '0;
      launch_q <= 1'b0;
    end
  end

  // Credit arithmetic: a return and a spend in the same cycle cancel out.
  always_comb begin
    crd_next = crd_count;
    ovf_set  = 1'b0;
    if (tx.TXREQLCRDV && !issue) begin
      if (crd_count == 4'(MAX_CRD)) ovf_set = 1'b1;
      else                          crd_next = crd_count + 4'd1;
    end else if (!tx.TXREQLCRDV && issue) begin
      crd_next = crd_count - 4'd1;
    end
  end

  // Credit counter and sticky overflow flag; credits returned during reset are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      crd_count    <= 4'd0;
      crd_overflow <= 1'b0;
    end else begin
      crd_count <= crd_next;
      if (ovf_set) crd_overflow <= 1'b1;
    end
  end

endmodule
